// File: rtl/oram_backend_stub.sv
// Path ORAM backend stand-in: answers reads with an address-derived
// pattern after a fixed latency and folds write beats into a checksum.
module oram_backend_stub #(
  parameter int ORAMU = 32,
  parameter int ORAMB = 512,
  parameter int FEDWidth = 512,
  parameter int Latency = 6,
  parameter int BECMDWidth = 2,
  parameter logic [BECMDWidth-1:0] BECMD_Read = BECMDWidth'(2)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [BECMDWidth-1:0] Command,
  input  logic [ORAMU-1:0]      PAddr,
  input  logic                  CommandValid,
  output logic                  CommandReady,
  input  logic [FEDWidth-1:0]   DataIn,
  input  logic                  DataInValid,
  output logic                  DataInReady,
  output logic [FEDWidth-1:0]   ReturnData,
  output logic                  ReturnDataValid,
  input  logic                  ReturnDataReady,
  output logic [31:0]           ReadCount,
  output logic [31:0]           WriteCount,
  output logic [FEDWidth-1:0]   WriteChecksum
);

  localparam int Beats = ORAMB / FEDWidth;
  localparam int Chunks = FEDWidth / ORAMU;
  localparam int BW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [BW-1:0] LastBeat = BW'(Beats - 1);
  localparam logic [7:0] LatInit = 8'(Latency);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND,
    RECV
  } state_t;

  state_t state, state_nxt;

  logic [7:0]          lat_cnt;
  logic [BW-1:0]       beat;
  logic [ORAMU-1:0]    addr_reg;
  logic [FEDWidth-1:0] rdata;
  logic [FEDWidth-1:0] csum;
  logic [31:0]         rd_cnt;
  logic [31:0]         wr_cnt;
  logic                cmd_fire;
  logic                ret_fire;
  logic                din_fire;
  logic                last;
  logic                lat_done;

  // Beat b carries consecutive words starting at base + b*Chunks.
  function automatic logic [FEDWidth-1:0] pattern(
    input logic [ORAMU-1:0] base,
    input logic [BW-1:0]    b
  );
    logic [FEDWidth-1:0] p;
    logic [ORAMU-1:0]    first;
    p = '0;
    first = base + ORAMU'(b) * ORAMU'(Chunks);
    for (int k = 0; k < Chunks; k++) begin
      p[k*ORAMU +: ORAMU] = first + ORAMU'(k);
    end
    return p;
  endfunction

  assign CommandReady    = (state == IDLE) & ~Reset;
  assign DataInReady     = (state == RECV);
  assign ReturnDataValid = (state == SEND);
  assign ReturnData      = rdata;
  assign ReadCount       = rd_cnt;
  assign WriteCount      = wr_cnt;
  assign WriteChecksum   = csum;

  assign cmd_fire = CommandValid & CommandReady;
  assign ret_fire = ReturnDataValid & ReturnDataReady;
  assign din_fire = DataInValid & DataInReady;
  assign last     = (beat == LastBeat);
  assign lat_done = (lat_cnt == 8'd0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cmd_fire) begin
          state_nxt = (Command == BECMD_Read) ? WAIT : RECV;
        end
      end
      WAIT: if (lat_done) state_nxt = SEND;
      SEND: if (ret_fire && last) state_nxt = IDLE;
      RECV: if (din_fire && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      lat_cnt  <= '0;
      beat     <= '0;
      addr_reg <= '0;
      rdata    <= '0;
      csum     <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
    end else begin
      if (cmd_fire) begin
        addr_reg <= PAddr;
        lat_cnt  <= LatInit;
      end
      if (state == WAIT) begin
        if (lat_done) rdata <= pattern(addr_reg, '0);
        else          lat_cnt <= lat_cnt - 8'd1;
      end
      if (ret_fire) begin
        if (last) begin
          rdata  <= '0;
          beat   <= '0;
          rd_cnt <= rd_cnt + 32'd1;
        end else begin
          rdata <= pattern(addr_reg, beat + BW'(1));
          beat  <= beat + BW'(1);
        end
      end
      if (din_fire) begin
        csum <= csum ^ DataIn;
        if (last) begin
          beat   <= '0;
          wr_cnt <= wr_cnt + 32'd1;
        end else begin
          beat <= beat + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_oram_backend_stub.sv
// Bench for oram_backend_stub: table vectors, corner sequences and a
// randomized phase against a block-level model of the stub.
module tb_oram_backend_stub;

  localparam int LAT = 6;
  localparam int BEATS = 4;
  localparam int CH = 4;
  localparam logic [1:0] RD = 2'd2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]   cmd;
  logic [31:0]  paddr;
  logic         cmd_v, cmd_r;
  logic [127:0] din;
  logic         din_v, din_r;
  logic [127:0] rdat;
  logic         rv, rr;
  logic [31:0]  rcnt, wcnt;
  logic [127:0] wck;

  logic [1:0]   u1_cmd;
  logic [31:0]  u1_paddr;
  logic         u1_cmd_v, u1_cmd_r;
  logic [511:0] u1_din;
  logic         u1_din_v, u1_din_r;
  logic [511:0] u1_rdat;
  logic         u1_rv, u1_rr;
  logic [31:0]  u1_rcnt, u1_wcnt;
  logic [511:0] u1_wck;

  oram_backend_stub #(
    .ORAMU(32), .ORAMB(512), .FEDWidth(128), .Latency(LAT),
    .BECMDWidth(2), .BECMD_Read(RD)
  ) dut (
    .Clock(clk), .Reset(rst),
    .Command(cmd), .PAddr(paddr),
    .CommandValid(cmd_v), .CommandReady(cmd_r),
    .DataIn(din), .DataInValid(din_v), .DataInReady(din_r),
    .ReturnData(rdat), .ReturnDataValid(rv),
    .ReturnDataReady(rr),
    .ReadCount(rcnt), .WriteCount(wcnt),
    .WriteChecksum(wck)
  );

  oram_backend_stub #(
    .ORAMU(32), .ORAMB(512), .FEDWidth(512), .Latency(0),
    .BECMDWidth(2), .BECMD_Read(RD)
  ) dut0 (
    .Clock(clk), .Reset(rst),
    .Command(u1_cmd), .PAddr(u1_paddr),
    .CommandValid(u1_cmd_v), .CommandReady(u1_cmd_r),
    .DataIn(u1_din), .DataInValid(u1_din_v),
    .DataInReady(u1_din_r),
    .ReturnData(u1_rdat), .ReturnDataValid(u1_rv),
    .ReturnDataReady(u1_rr),
    .ReadCount(u1_rcnt), .WriteCount(u1_wcnt),
    .WriteChecksum(u1_wck)
  );

  int checks = 0;
  int errors = 0;

  int unsigned  m_rd;
  int unsigned  m_wr;
  logic [127:0] m_ck;

  typedef struct {
    logic         rd;
    logic [31:0]  addr;
    int           mode;
    logic [127:0] fill;
    logic [31:0]  exp;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Word i of a read block is addr+i; beat b holds words b*CH .. b*CH+CH-1.
  function automatic logic [127:0] model_beat(input logic [31:0] a,
                                              input int b);
    logic [31:0]  words[BEATS*CH];
    logic [127:0] r;
    for (int i = 0; i < BEATS*CH; i++) words[i] = a + 32'(i);
    for (int k = 0; k < CH; k++) r[k*32 +: 32] = words[b*CH + k];
    return r;
  endfunction

  function automatic logic ready_for(input int mode, input int j);
    case (mode)
      1: return 1'b1;
      2: return (j % 4 == 0) || (j % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic issue(input logic [1:0] c, input logic [31:0] a);
    int n;
    @(negedge clk);
    cmd_v = 1'b1;
    cmd = c;
    paddr = a;
    n = 0;
    while (!cmd_r && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready", cmd_r, 1'b1);
    @(posedge clk);
    #1;
    cmd_v = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int mode,
                         output logic [127:0] lb);
    int cyc, b, j, first;
    lb = '0;
    issue(RD, a);
    cyc = 0;
    b = 0;
    j = 0;
    first = -1;
    while (b < BEATS && cyc < 300) begin
      @(negedge clk);
      cyc++;
      check("rd_din_ready", din_r, 1'b0);
      din_v = 1'b1;
      din = {$urandom, $urandom, $urandom, $urandom};
      if (first < 0 && rv) begin
        first = cyc;
        check("rd_latency", 512'(cyc), 512'(LAT + 2));
      end
      if (first >= 0) begin
        check("rd_valid_hold", rv, 1'b1);
        check("rd_data", rdat, model_beat(a, b));
        rr = ready_for(mode, j);
        j++;
        if (rr && rv) begin
          lb = rdat;
          b++;
        end
      end else begin
        rr = 1'($urandom_range(0, 1));
      end
    end
    check("rd_beats", 512'(b), 512'(BEATS));
    @(negedge clk);
    rr = 1'b0;
    din_v = 1'b0;
    m_rd++;
    check("rd_count", rcnt, m_rd);
    check("rd_idle_ready", cmd_r, 1'b1);
    check("rd_done_valid", rv, 1'b0);
    check("rd_checksum_kept", wck, m_ck);
  endtask

  task automatic do_write(input logic [1:0] c,
                          input logic [3:0][127:0] w);
    int cyc, b;
    issue(c, $urandom);
    cyc = 0;
    b = 0;
    while (b < BEATS && cyc < 300) begin
      @(negedge clk);
      cyc++;
      check("wr_din_ready", din_r, 1'b1);
      check("wr_no_rvalid", rv, 1'b0);
      check("wr_cmd_ready", cmd_r, 1'b0);
      din = w[b];
      din_v = ($urandom_range(0, 3) != 0);
      if (din_v) begin
        m_ck = m_ck ^ w[b];
        b++;
      end
    end
    check("wr_beats", 512'(b), 512'(BEATS));
    @(negedge clk);
    din_v = 1'b0;
    m_wr++;
    check("wr_count", wcnt, m_wr);
    check("wr_checksum", wck, m_ck);
    check("wr_idle_din_ready", din_r, 1'b0);
    check("wr_idle_ready", cmd_r, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [127:0]       lb;
    logic [3:0][127:0]  w;
    logic [511:0]       e;
    logic [1:0]         c;
    int cyc, acc, prev, hs;

    rst = 1'b1;
    cmd = '0; paddr = '0; cmd_v = 1'b0;
    din = '0; din_v = 1'b0; rr = 1'b0;
    u1_cmd = '0; u1_paddr = '0; u1_cmd_v = 1'b0;
    u1_din = '0; u1_din_v = 1'b0; u1_rr = 1'b0;
    m_rd = 0; m_wr = 0; m_ck = '0;

    @(negedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_r, 1'b0);
    check("rst_rvalid", rv, 1'b0);
    check("rst_din_ready", din_r, 1'b0);
    check("rst_rdata", rdat, '0);
    check("rst_counts", {rcnt, wcnt}, '0);
    check("rst_checksum", wck, '0);
    check("rst_u1_cmd_ready", u1_cmd_r, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_cmd_ready", cmd_r, 1'b1);
    check("rel_u1_cmd_ready", u1_cmd_r, 1'b1);
    check("rel_rvalid", rv, 1'b0);

    // Latency 0 with address wrap on the single-beat instance.
    u1_cmd_v = 1'b1;
    u1_cmd = RD;
    u1_paddr = 32'hFFFF_FFFE;
    u1_rr = 1'b1;
    @(posedge clk);
    #1;
    u1_cmd_v = 1'b0;
    @(negedge clk);
    check("l0_wait_valid", u1_rv, 1'b0);
    @(negedge clk);
    check("l0_valid", u1_rv, 1'b1);
    for (int k = 0; k < 16; k++) e[k*32 +: 32] = 32'hFFFF_FFFE + 32'(k);
    check("l0_wrap_data", u1_rdat, e);
    @(negedge clk);
    check("l0_count", u1_rcnt, 32'd1);
    check("l0_ready", u1_cmd_r, 1'b1);
    check("l0_done_valid", u1_rv, 1'b0);

    tbl[0] = '{rd: 1'b1, addr: 32'h100, mode: 1, fill: '0,
               exp: 32'h10F};
    tbl[1] = '{rd: 1'b1, addr: 32'h20, mode: 2, fill: '0,
               exp: 32'h2F};
    tbl[2] = '{rd: 1'b0, addr: 32'h0, mode: 0,
               fill: {16{8'hA5}}, exp: 32'hFFFF_FFFF};
    tbl[3] = '{rd: 1'b0, addr: 32'h0, mode: 0,
               fill: {16{8'h3C}}, exp: 32'h0};
    tbl[4] = '{rd: 1'b1, addr: 32'hFFFF_FFFE, mode: 1, fill: '0,
               exp: 32'h0000_000D};
    tbl[5] = '{rd: 1'b1, addr: 32'hFFFF_FFF0, mode: 3, fill: '0,
               exp: 32'hFFFF_FFFF};

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].rd) begin
        do_read(tbl[i].addr, tbl[i].mode, lb);
        check("tbl_last_chunk", lb[127:96], tbl[i].exp);
      end else begin
        w[0] = tbl[i].fill;
        w[1] = ~tbl[i].fill;
        w[2] = '0;
        w[3] = '0;
        do_write(2'd0, w);
        check("tbl_checksum", wck[31:0], tbl[i].exp);
      end
    end

    // Back-to-back reads with Valid and Ready held high.
    @(negedge clk);
    cmd_v = 1'b1;
    cmd = RD;
    paddr = 32'h300;
    rr = 1'b1;
    cyc = 0;
    acc = 0;
    prev = -1;
    while (cyc < 200) begin
      if (cmd_r) begin
        if (prev >= 0) check("rr_interval", 512'(cyc - prev),
                             512'(LAT + BEATS + 2));
        prev = cyc;
        acc++;
      end
      if (acc == 3) break;
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1;
    cmd_v = 1'b0;
    check("rr_accepts", 512'(acc), 512'(3));
    repeat (LAT + BEATS + 3) @(negedge clk);
    m_rd += 3;
    check("rr_count", rcnt, m_rd);
    rr = 1'b0;

    // Reset while beat 2 of 4 is being presented.
    issue(RD, 32'h40);
    hs = 0;
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (rv && hs == 2) break;
      rr = 1'b1;
      if (rv) hs++;
    end
    check("ms_beat2", rdat, model_beat(32'h40, 2));
    rst = 1'b1;
    #1;
    check("ms_valid_drop", rv, 1'b0);
    check("ms_rdata", rdat, '0);
    check("ms_cmd_ready", cmd_r, 1'b0);
    m_rd = 0;
    m_wr = 0;
    m_ck = '0;
    @(negedge clk);
    check("ms_read_count", rcnt, m_rd);
    check("ms_checksum", wck, m_ck);
    rst = 1'b0;
    rr = 1'b0;
    @(negedge clk);
    check("ms_rel_ready", cmd_r, 1'b1);
    check("ms_rel_valid", rv, 1'b0);
    do_read(32'h80, 1, lb);
    check("ms_next_last", lb[127:96], 32'h8F);

    // Randomized traffic against the model.
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_read($urandom, $urandom_range(1, 3), lb);
      end else begin
        for (int b = 0; b < BEATS; b++)
          w[b] = {$urandom, $urandom, $urandom, $urandom};
        c = 2'($urandom_range(0, 2));
        if (c == RD) c = 2'd3;
        do_write(c, w);
      end
    end
    check("final_wcount", wcnt, m_wr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
